// File: rtl/ycbcr_pkg.sv
// Shared constants for the RGB -> BT.601 studio-range YCbCr converter.
// The coefficients are Q0.10 fixed point. Rows are Y, Cb, Cr; columns are R, G, B.
package ycbcr_pkg;

  localparam int unsigned FRAC  = 10;
  localparam int unsigned ACC_W = 23;
  localparam int unsigned KW    = 10;
  localparam int unsigned ROUND = 512;
  localparam int unsigned Y_OFF = 64;
  localparam int unsigned C_OFF = 512;

  localparam logic [KW-1:0] K_YR  = 10'd263;
  localparam logic [KW-1:0] K_YG  = 10'd516;
  localparam logic [KW-1:0] K_YB  = 10'd100;
  localparam logic [KW-1:0] K_CBR = 10'd152;
  localparam logic [KW-1:0] K_CBG = 10'd298;
  localparam logic [KW-1:0] K_CBB = 10'd450;
  localparam logic [KW-1:0] K_CRR = 10'd450;
  localparam logic [KW-1:0] K_CRG = 10'd377;
  localparam logic [KW-1:0] K_CRB = 10'd73;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

endpackage

// File: rtl/ycc_sat.sv
// Shifts one signed fixed-point accumulator down by FRAC bits.
// It then clamps the result to the unsigned range of a DW-bit pixel.
module ycc_sat import ycbcr_pkg::*; #(
  parameter int unsigned FRAC = 10,
  parameter int unsigned DW   = 10
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [DW-1:0]    pix
);

  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DW) - 1);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc >>> FRAC;
    if (shifted < 0)
      pix = '0;
    else if (shifted > PIX_MAX)
      pix = '1;
    else
      pix = shifted[DW-1:0];
  end

endmodule

// File: rtl/rgb2ycbcr.sv
// Three-stage RGB -> YCbCr converter: products, then sums, then clamp and register.
// A 4:2:2 chroma stream is produced using the even/odd phase that travels with each pixel.
module rgb2ycbcr import ycbcr_pkg::*; #(
  parameter int unsigned FRAC = 10,
  parameter int unsigned DW   = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] R,
  input  logic [DW-1:0] G,
  input  logic [DW-1:0] B,
  input  logic          data_valid_in,
  input  logic          sol,
  output logic [DW-1:0] Y,
  output logic [DW-1:0] Cb,
  output logic [DW-1:0] Cr,
  output logic [DW-1:0] C422,
  output logic          c422_is_cr,
  output logic          data_valid_out
);

  localparam int unsigned PW = DW + KW;
  localparam logic signed [ACC_W-1:0] Y_BASE = ACC_W'((Y_OFF << FRAC) + ROUND);
  localparam logic signed [ACC_W-1:0] C_BASE = ACC_W'((C_OFF << FRAC) + ROUND);
  localparam logic [KW-1:0] COEF [9] = '{K_YR, K_YG, K_YB, K_CBR, K_CBG, K_CBB,
                                         K_CRR, K_CRG, K_CRB};

  function automatic logic signed [ACC_W-1:0] ext(input logic [PW-1:0] p);
    return ACC_W'(p);
  endfunction

  // Stage 1 state. The pixel phase is resolved here and travels with the products.
  phase_e          phase;
  phase_e          pix_phase;
  phase_e          ph1;
  phase_e          ph2;
  logic            v1;
  logic            v2;
  logic [DW-1:0]   comp [9];
  logic [PW-1:0]   prod [9];

  // Stage 2 state
  logic signed [ACC_W-1:0] acc_y,  acc_cb,  acc_cr;
  logic signed [ACC_W-1:0] sum_y,  sum_cb,  sum_cr;
  logic        [DW-1:0]    y_sat,  cb_sat,  cr_sat;

  always_comb begin
    pix_phase = sol ? PH_EVEN : phase;
    comp = '{R, G, B, R, G, B, R, G, B};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= PH_EVEN;
      ph1   <= PH_EVEN;
      v1    <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) prod[i] <= '0;
    end else begin
      v1 <= data_valid_in;
      if (data_valid_in) begin
        phase <= (pix_phase == PH_EVEN) ? PH_ODD : PH_EVEN;
        ph1   <= pix_phase;
        for (int unsigned i = 0; i < 9; i++)
          prod[i] <= PW'(COEF[i]) * PW'(comp[i]);
      end else if (sol) begin
        phase <= PH_EVEN;
      end
    end
  end

  always_comb begin
    sum_y  = Y_BASE + ext(prod[0]) + ext(prod[1]) + ext(prod[2]);
    sum_cb = C_BASE - ext(prod[3]) - ext(prod[4]) + ext(prod[5]);
    sum_cr = C_BASE + ext(prod[6]) - ext(prod[7]) - ext(prod[8]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2     <= 1'b0;
      ph2    <= PH_EVEN;
      acc_y  <= '0;
      acc_cb <= '0;
      acc_cr <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        ph2    <= ph1;
        acc_y  <= sum_y;
        acc_cb <= sum_cb;
        acc_cr <= sum_cr;
      end
    end
  end

  ycc_sat #(.FRAC(FRAC), .DW(DW)) u_sat_y  (.acc(acc_y),  .pix(y_sat));
  ycc_sat #(.FRAC(FRAC), .DW(DW)) u_sat_cb (.acc(acc_cb), .pix(cb_sat));
  ycc_sat #(.FRAC(FRAC), .DW(DW)) u_sat_cr (.acc(acc_cr), .pix(cr_sat));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_valid_out <= 1'b0;
      Y              <= '0;
      Cb             <= '0;
      Cr             <= '0;
      C422           <= '0;
      c422_is_cr     <= 1'b0;
    end else begin
      data_valid_out <= v2;
      if (v2) begin
        Y          <= y_sat;
        Cb         <= cb_sat;
        Cr         <= cr_sat;
        C422       <= (ph2 == PH_ODD) ? cr_sat : cb_sat;
        c422_is_cr <= (ph2 == PH_ODD);
      end
    end
  end

endmodule

// File: tb/tb_rgb2ycbcr.sv
// Directed bench for rgb2ycbcr. Every pixel carries hand-computed Y/Cb/Cr values and its expected phase.
// During idle cycles the outputs must hold the values of the last valid pixel.
module tb_rgb2ycbcr;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] R = '0, G = '0, B = '0;
  logic       data_valid_in = 1'b0;
  logic       sol = 1'b0;
  logic [9:0] Y, Cb, Cr, C422;
  logic       c422_is_cr, data_valid_out;

  rgb2ycbcr #(.FRAC(10), .DW(10)) dut (
    .clk(clk), .rst(rst), .R(R), .G(G), .B(B),
    .data_valid_in(data_valid_in), .sol(sol),
    .Y(Y), .Cb(Cb), .Cr(Cr), .C422(C422),
    .c422_is_cr(c422_is_cr), .data_valid_out(data_valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit dv; bit sol; int r; int g; int b;
    int y; int cb; int cr; bit odd;
  } stim_t;

  stim_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int last_y = 0, last_cb = 0, last_cr = 0, last_c422 = 0, last_odd = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic stim_t px(int r, int g, int b, bit s, int y, int cb, int cr, bit odd);
    stim_t e;
    e.dv = 1'b1; e.sol = s; e.r = r; e.g = g; e.b = b;
    e.y = y; e.cb = cb; e.cr = cr; e.odd = odd;
    return e;
  endfunction

  function automatic stim_t idle(bit s);
    stim_t e;
    e = px(0, 0, 0, s, 0, 0, 0, 1'b0);
    e.dv = 1'b0;
    return e;
  endfunction

  task automatic drive(input stim_t e);
    data_valid_in = e.dv;
    sol = e.sol;
    R = e.r[9:0]; G = e.g[9:0]; B = e.b[9:0];
  endtask

  task automatic check_entry(input int idx, input stim_t e);
    check_val($sformatf("dv[%0d]", idx), int'(data_valid_out), int'(e.dv));
    if (e.dv) begin
      last_y = e.y; last_cb = e.cb; last_cr = e.cr;
      last_c422 = e.odd ? e.cr : e.cb;
      last_odd = int'(e.odd);
    end
    check_val($sformatf("y[%0d]", idx),    int'(Y),          last_y);
    check_val($sformatf("cb[%0d]", idx),   int'(Cb),         last_cb);
    check_val($sformatf("cr[%0d]", idx),   int'(Cr),         last_cr);
    check_val($sformatf("c422[%0d]", idx), int'(C422),       last_c422);
    check_val($sformatf("iscr[%0d]", idx), int'(c422_is_cr), last_odd);
  endtask

  // Inputs are driven on the falling edge; the result of entry c-3 is visible on falling edge c.
  task automatic run_queue();
    int n;
    n = q.size();
    for (int c = 0; c < n + 3; c++) begin
      @(negedge clk);
      if (c >= 3) check_entry(c - 3, q[c - 3]);
      if (c < n) drive(q[c]);
      else       drive(idle(1'b0));
    end
    q.delete();
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_dv"},   int'(data_valid_out), 0);
    check_val({tag, "_y"},    int'(Y),    0);
    check_val({tag, "_cb"},   int'(Cb),   0);
    check_val({tag, "_cr"},   int'(Cr),   0);
    check_val({tag, "_c422"}, int'(C422), 0);
    check_val({tag, "_iscr"}, int'(c422_is_cr), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst = 1'b1;

    // Black, white and red; then the valid pattern 1,0,1,1,0,1 with holds during the gaps
    q.push_back(px(0, 0, 0, 1, 64, 512, 512, 0));
    q.push_back(idle(0));
    q.push_back(px(1023, 1023, 1023, 1, 942, 512, 512, 0));
    q.push_back(px(1023, 0, 0, 1, 327, 360, 962, 0));
    q.push_back(idle(0));
    q.push_back(px(0, 1023, 0, 1, 579, 214, 135, 0));
    q.push_back(idle(0));
    q.push_back(px(0, 0, 1023, 0, 164, 962, 439, 1));
    q.push_back(px(512, 512, 512, 0, 504, 512, 512, 0));
    q.push_back(idle(0));
    q.push_back(px(1023, 0, 0, 0, 327, 360, 962, 1));
    q.push_back(idle(0));
    // A five-pixel line, a gap, then a two-pixel line
    q.push_back(px(0, 0, 0, 1, 64, 512, 512, 0));
    q.push_back(px(1023, 1023, 1023, 0, 942, 512, 512, 1));
    q.push_back(px(1023, 0, 0, 0, 327, 360, 962, 0));
    q.push_back(px(0, 1023, 0, 0, 579, 214, 135, 1));
    q.push_back(px(0, 0, 1023, 0, 164, 962, 439, 0));
    q.push_back(idle(0));
    q.push_back(idle(0));
    q.push_back(px(512, 512, 512, 1, 504, 512, 512, 0));
    q.push_back(px(1023, 1023, 1023, 0, 942, 512, 512, 1));
    q.push_back(idle(0));
    // Leave the stored phase at odd, then re-arm it with a lone sol pulse
    q.push_back(px(1023, 0, 0, 1, 327, 360, 962, 0));
    q.push_back(idle(1));
    q.push_back(idle(0));
    q.push_back(px(0, 0, 1023, 0, 164, 962, 439, 0));
    run_queue();

    // Reset with two pixels inside the pipeline and a third on the inputs
    @(negedge clk); drive(px(0, 1023, 0, 0, 0, 0, 0, 0));
    @(negedge clk); drive(px(512, 512, 512, 0, 0, 0, 0, 0));
    @(negedge clk); drive(px(1023, 1023, 1023, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #1 check_zero("mid");
    drive(idle(0));
    @(negedge clk); check_zero("hold1");
    @(negedge clk); check_zero("hold2");
    rst = 1'b1;
    last_y = 0; last_cb = 0; last_cr = 0; last_c422 = 0; last_odd = 0;

    q.push_back(idle(0));
    q.push_back(idle(0));
    q.push_back(idle(0));
    q.push_back(idle(0));
    q.push_back(px(1023, 1023, 1023, 0, 942, 512, 512, 0));
    q.push_back(px(1023, 0, 0, 0, 327, 360, 962, 1));
    q.push_back(idle(0));
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
